// File: rtl/ans_lifo.sv
// Nibble LIFO that reverses the ans encoder stream: fills until a last-flagged push, then drains in reverse order.
// Optional sticky overflow detection on err is built when ANS_LIFO_OVF_EN is defined.
module ans_lifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_last,
    input  logic                       in_vld,
    output logic                       in_rdy,
    output logic [WIDTH-1:0]           out,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] FULL = PW'(DEPTH);
    localparam logic [PW-1:0] ONE  = PW'(1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign wr_idx = AW'(ptr);
    assign rd_idx = AW'(ptr - ONE);
    assign level  = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Storage carries no reset; ptr alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= in;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        out       = '0;
        push      = 1'b0;
        case (state)
            FILL: begin
                in_rdy = (ptr != FULL);
                if (in_vld && in_rdy && !clear) begin
                    push    = 1'b1;
                    ptr_nxt = ptr + ONE;
                    if (in_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_vld = 1'b1;
                out     = mem[rd_idx];
                if (out_rdy) begin
                    ptr_nxt = ptr - ONE;
                    if (ptr == ONE) state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
        if (clear) begin
            ptr_nxt   = '0;
            state_nxt = FILL;
        end
    end

`ifdef ANS_LIFO_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         err <= 1'b0;
        else if (clear)                                     err <= 1'b0;
        else if (state == FILL && in_vld && ptr == FULL)    err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ans_lifo.sv
// Self-checking bench for ans_lifo: directed test-plan scenarios plus randomized traffic
// against a queue-based stack model.
module tb_ans_lifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             in_last = 1'b0;
    logic             in_vld = 1'b0;
    logic             in_rdy;
    logic [WIDTH-1:0] dout;
    logic             out_vld;
    logic             out_rdy = 1'b0;
    logic [LW-1:0]    level;
    logic             err;

    ans_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in(din), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
        .out(dout), .out_vld(out_vld), .out_rdy(out_rdy),
        .level(level), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: the stack is a queue (back = top), plus a draining flag and sticky error.
    logic [WIDTH-1:0] stk[$];
    bit               m_drain = 0;
    bit               m_err = 0;
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        stk.delete();
        m_drain = 0;
        m_err = 0;
    endtask

    // Compare all outputs before the edge, advance the model by one edge, then move to the next negedge.
    task automatic cycle();
        int e_out;
        e_out = 0;
        if (m_drain) e_out = stk[$];
        check("in_rdy", 32'(in_rdy), 32'(!m_drain && stk.size() < DEPTH));
        check("out_vld", 32'(out_vld), 32'(m_drain));
        check("out", 32'(dout), 32'(e_out));
        check("level", 32'(level), 32'(stk.size()));
        check("err", 32'(err), 32'(m_err));
        if (clear) begin
            model_reset();
        end else if (!m_drain) begin
            if (in_vld && stk.size() < DEPTH) begin
                stk.push_back(din);
                if (in_last) m_drain = 1;
            end else if (in_vld) begin
`ifdef ANS_LIFO_OVF_EN
                m_err = 1;
`endif
            end
        end else if (out_rdy) begin
            void'(stk.pop_back());
            if (stk.size() == 0) m_drain = 0;
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] v, input logic last);
        in_vld = 1'b1; din = v; in_last = last; out_rdy = 1'b0; clear = 1'b0;
        cycle();
        in_vld = 1'b0; in_last = 1'b0;
    endtask

    logic [WIDTH-1:0] seq[4];
    logic [WIDTH-1:0] held;

    initial begin
        seq[0] = 4'h3; seq[1] = 4'h7; seq[2] = 4'h9; seq[3] = 4'hA;
        @(negedge clk);
        cycle();                        // reset values while rst_n is low
        rst_n = 1'b1;
        @(negedge clk);

        // Basic reversal with continuous out_rdy
        for (int i = 0; i < 4; i++) push(seq[i], i == 3);
        out_rdy = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            check("seq_out", 32'(dout), 32'(seq[i]));
            cycle();
        end
        out_rdy = 1'b0;
        check("refill_rdy", 32'(in_rdy), 32'd1);
        cycle();

        // Same stream with out_rdy toggling; out must hold during stalls
        for (int i = 0; i < 4; i++) push(seq[i], i == 3);
        for (int i = 0; i < 8; i++) begin
            out_rdy = (i % 2 == 0);
            held = dout;
            cycle();
            if (i % 2 == 1) check("stall_hold", 32'(dout), 32'(held));
        end
        out_rdy = 1'b0;
        check("toggle_done", 32'(level), 32'd0);

        // Full without last, then keep offering
        for (int i = 0; i < 4; i++) push(4'(i + 1), 1'b0);
        in_vld = 1'b1; din = 4'hF;
        cycle();
        cycle();
        in_vld = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();

        // Single nibble block
        push(4'h5, 1'b1);
        out_rdy = 1'b1;
        check("single_out", 32'(dout), 32'h5);
        cycle();
        cycle();
        out_rdy = 1'b0;

        // Asynchronous reset mid-drain after two pops
        for (int i = 0; i < 4; i++) push(seq[i], i == 3);
        out_rdy = 1'b1;
        cycle();
        cycle();
        out_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        push(4'h1, 1'b0);
        push(4'h2, 1'b1);
        out_rdy = 1'b1;
        cycle();
        cycle();
        cycle();
        out_rdy = 1'b0;

        // Clear coinciding with a push handshake
        in_vld = 1'b1; din = 4'hC; clear = 1'b1;
        cycle();
        in_vld = 1'b0; clear = 1'b0;
        check("clear_push", 32'(level), 32'd0);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            din     = 4'($urandom);
            in_last = ($urandom_range(0, 4) == 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            clear   = ($urandom_range(0, 40) == 0);
            cycle();
        end
        in_vld = 1'b0; clear = 1'b0; out_rdy = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
